// File: rtl/rr_arb_sel4.sv
// rr_arb_sel4: 4-channel round-robin arbiter producing the registered select
// for the downstream 4:1 data mux. A grant is held until the owner reports
// done, drops its request, or the hold limit expires. Every release is
// followed by one idle cycle before the next grant.
//
// state | meaning
// IDLE  | no owner; pick the next requester after `last` in rotating order
// GRANT | one channel owns the mux; hold counter advances each cycle

module rr_arb_sel4 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       valid,
    output logic       timeout
);

    // Hold counter width; it counts 0..MAX_HOLD-1 and never wraps.
    localparam int CW = $clog2(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q,   state_d;
    logic [3:0]      grant_q,   grant_d;
    logic [1:0]      sel_q,     sel_d;
    logic            valid_q,   valid_d;
    logic            timeout_q, timeout_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [1:0]      last_q,    last_d;

    logic [1:0]      win;
    logic            win_found;
    logic [1:0]      idx;

    // Rotating priority search: last+1, last+2, last+3, then last itself.
    always_comb begin
        win       = 2'd0;
        win_found = 1'b0;
        idx       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!win_found && req[idx]) begin
                win       = idx;
                win_found = 1'b1;
            end
        end
    end

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        last_d    = last_q;

        case (state_q)
            IDLE: begin
                // done is meaningless without an owner and is ignored here.
                if (win_found) begin
                    state_d = GRANT;
                    grant_d = 4'b0001 << win;
                    sel_d   = win;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    grant_d = 4'b0000;
                    valid_d = 1'b0;
                end
            end
            GRANT: begin
                // Release keeps sel unchanged so the mux select stays stable.
                if (done || !req[sel_q]) begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    valid_d = 1'b0;
                    last_d  = sel_q;
                end else if (cnt_q == CW'(MAX_HOLD - 1)) begin
                    state_d   = IDLE;
                    grant_d   = 4'b0000;
                    valid_d   = 1'b0;
                    last_d    = sel_q;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset leaves channel 0 at top priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            sel_q     <= 2'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            last_q    <= 2'd3;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb_sel4.sv
// tb_rr_arb_sel4: directed checks of rr_arb_sel4 with MAX_HOLD=16.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_rr_arb_sel4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_arb_sel4 #(.MAX_HOLD(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .sel     (sel),
        .valid   (valid),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic v, input logic t);
        check({tag, ".grant"},   {4'b0, grant},   {4'b0, g});
        check({tag, ".sel"},     {6'b0, sel},     {6'b0, s});
        check({tag, ".valid"},   {7'b0, valid},   {7'b0, v});
        check({tag, ".timeout"}, {7'b0, timeout}, {7'b0, t});
    endtask

    // Structural invariants sampled every falling edge outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            check("inv.onehot0", {7'b0, $onehot0(grant)}, 8'd1);
            check("inv.valid_eq_or", {7'b0, valid}, {7'b0, |grant});
            if (valid) check("inv.grant_sel", {7'b0, grant[sel]}, 8'd1);
            if (timeout) check("inv.timeout_nvalid", {7'b0, valid}, 8'd0);
        end
    end

    initial begin
        logic [1:0] order [5];
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;

        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        #12;
        check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // 1: full request, done one cycle after each grant
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out($sformatf("t1.grant%0d", i), 4'b0001 << order[i], order[i], 1'b1, 1'b0);
            done = 1'b1;
            tick();
            check_out($sformatf("t1.gap%0d", i), 4'b0000, order[i], 1'b0, 1'b0);
            done = 1'b0;
        end

        // 2: single requester held until expiry
        req = 4'b0100;
        tick();
        check_out("t2.first", 4'b0100, 2'd2, 1'b1, 1'b0);
        for (int i = 1; i < 16; i++) begin
            tick();
            check_out($sformatf("t2.hold%0d", i), 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        tick();
        check_out("t2.expire", 4'b0000, 2'd2, 1'b0, 1'b1);
        tick();
        check_out("t2.regrant", 4'b0100, 2'd2, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        check_out("t2.release", 4'b0000, 2'd2, 1'b0, 1'b0);
        done = 1'b0;

        // 3: owner drops request, other channel takes over after a gap
        req = 4'b0010;
        tick();
        check_out("t3.grant1", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        check_out("t3.hold1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1000;
        tick();
        check_out("t3.drop", 4'b0000, 2'd1, 1'b0, 1'b0);
        tick();
        check_out("t3.grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        check_out("t3.release", 4'b0000, 2'd3, 1'b0, 1'b0);
        done = 1'b0;

        // 4: done coincides with hold expiry -> no timeout pulse
        req = 4'b0001;
        tick();
        check_out("t4.grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int i = 1; i < 16; i++) tick();
        check_out("t4.last_held", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        check_out("t4.done_expiry", 4'b0000, 2'd0, 1'b0, 1'b0);
        done = 1'b0;

        // 5: asynchronous reset in the middle of a grant
        req = 4'b0100;
        tick();
        check_out("t5.grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_out("t5.async_clear", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0101;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_out("t5.ptr_reset", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        check_out("t5.release", 4'b0000, 2'd0, 1'b0, 1'b0);
        done = 1'b0;

        // 6: done toggling while idle has no effect
        req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            done = ~done;
            tick();
            check_out($sformatf("t6.idle%0d", i), 4'b0000, 2'd0, 1'b0, 1'b0);
        end
        done = 1'b0;
        req  = 4'b1111;
        tick();
        check_out("t6.rotation_kept", 4'b0010, 2'd1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
